// File: rtl/div_unit.sv
// Purpose    : multicycle signed restoring divider, quotient -> lo_out, remainder -> hi_out.
// Latency    : div_start sampled at edge 0, results and div_done registered at edge WIDTH+1.
// Backpressure: none; div_start while busy (RUN or FINISH) is ignored, divisor==0 gives a divzero pulse.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   div_start  one-cycle request, operands sampled on this edge when idle
//   dividend   signed dividend (register A)
//   divisor    signed divisor (register B)
//   hi_out     remainder (sign of the dividend), held until the next successful division
//   lo_out     quotient (truncated toward zero), held until the next successful division
//   div_done   one-cycle pulse, results valid from this cycle on
//   divzero    one-cycle pulse, divisor was zero and nothing was computed
//   busy       high while the iteration runs
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             div_done,
    output logic             divzero,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dsr;
    logic             r_sign_q;
    logic             r_sign_r;

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic             r_dz;
    logic             r_busy;

    logic             w_start_ok;
    logic             w_start_zero;
    logic             w_done_nxt;
    logic             w_dz_nxt;
    logic             w_busy_nxt;

    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dsr_mag;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH-1:0] w_rem_sub;
    logic             w_ge;
    logic [WIDTH-1:0] w_lo_res;
    logic [WIDTH-1:0] w_hi_res;

    // Magnitudes as unsigned WIDTH-bit values; negating the most negative
    // number yields 2^(WIDTH-1), which is exactly its unsigned magnitude.
    assign w_dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign w_dsr_mag = divisor[WIDTH-1]  ? -divisor  : divisor;

    assign w_start_ok   = (r_state == S_IDLE) && div_start && (divisor != '0);
    assign w_start_zero = (r_state == S_IDLE) && div_start && (divisor == '0);

    // Restoring step. The partial remainder is always below the divisor
    // magnitude, so the shifted value needs one extra bit for the compare;
    // when the subtract is taken the difference fits back into WIDTH bits.
    assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_dsr});
    assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_dsr;

    assign w_lo_res = r_sign_q ? -r_quo : r_quo;
    assign w_hi_res = r_sign_r ? -r_rem : r_rem;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and next values of the registered control outputs
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_dz_nxt    = 1'b0;
        w_busy_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = S_RUN;
                    w_busy_nxt  = 1'b1;
                end else if (w_start_zero) begin
                    w_dz_nxt = 1'b1;
                end
            end
            S_RUN: begin
                // r_cnt==1 means this edge performs the last quotient bit
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = S_FINISH;
                end else begin
                    w_busy_nxt = 1'b1;
                end
            end
            S_FINISH: begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dsr    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_dz     <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
            r_dz   <= w_dz_nxt;
            r_busy <= w_busy_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_quo    <= w_dvd_mag;
                        r_dsr    <= w_dsr_mag;
                        r_rem    <= '0;
                        r_cnt    <= CW'(WIDTH);
                        r_sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        r_sign_r <= dividend[WIDTH-1];
                    end
                end
                S_RUN: begin
                    r_rem <= w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt - CW'(1);
                end
                S_FINISH: begin
                    r_lo <= w_lo_res;
                    r_hi <= w_hi_res;
                end
                default: begin
                end
            endcase
        end
    end

    assign hi_out   = r_hi;
    assign lo_out   = r_lo;
    assign div_done = r_done;
    assign divzero  = r_dz;
    assign busy     = r_busy;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multicycle signed divider that serves the control unit's `div_start` / `divzero` handshake.
- Computes quotient into LO and remainder into HI for the R-type `div` instruction, one quotient bit per cycle.
- Sits in the datapath beside the multiplier, fed from the A/B registers.
- Its HI/LO results are written to the HI/LO registers through the `HiLoSrc` mux when the control unit sees `div_done`.

Parameters:
- WIDTH, 32, operand and result width in bits.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `div_start`  in  1  one-cycle request from the control unit; operands are sampled on this edge.
- `dividend`  in  WIDTH  signed dividend (register A).
- `divisor`  in  WIDTH  signed divisor (register B).
- `hi_out`  out  WIDTH  remainder result.
- `lo_out`  out  WIDTH  quotient result.
- `div_done`  out  1  one-cycle pulse; results are valid from this cycle on.
- `divzero`  out  1  one-cycle pulse; the divisor was zero and no division was performed.
- `busy`  out  1  high while the iteration is in progress.

Behaviour:
- Reset (async, active-high):
  - state is IDLE;
  - `hi_out`, `lo_out`, `div_done`, `divzero` and `busy` are all 0;
  - internal remainder, quotient and counter are cleared.
- A reset asserted mid-division aborts the division. No `div_done` is produced afterwards.
- States: IDLE, RUN, FINISH.
- IDLE:
  - `div_start`=1 and `divisor`==0: `divzero`=1 for exactly the next cycle; state stays IDLE; `hi_out`/`lo_out` keep their previous values.
  - `div_start`=1 and `divisor`!=0: latch |dividend| and |divisor| as unsigned WIDTH-bit magnitudes (|-2^31| = 0x80000000). Latch sign_q = dividend[MSB] XOR divisor[MSB] and sign_r = dividend[MSB]. Clear the partial remainder, load counter=WIDTH, go to RUN, `busy`=1.
- RUN, restoring step each cycle:
  - rem' = {rem[WIDTH-2:0], quo[MSB]}, computed in WIDTH+1 bits;
  - quo shifts left;
  - if rem' >= divisor magnitude: rem = rem' - divisor magnitude and quo[0]=1; otherwise rem = rem' and quo[0]=0;
  - counter decrements; when counter reaches 0 after the step, go to FINISH.
- FINISH, single cycle:
  - `lo_out` = sign_q ? -quo : quo (two's complement);
  - `hi_out` = sign_r ? -rem : rem;
  - `div_done`=1 for one cycle; `busy`=0; return to IDLE.
- Latency: `div_start` sampled at edge 0. RUN occupies edges 1..WIDTH. Results and `div_done` are registered at edge WIDTH+1, i.e. edge 33 for WIDTH=32.
- Results hold until the next successful division completes or reset.
- `div_start` while `busy` (RUN or FINISH) is ignored. Operands are not re-sampled and the running division is unaffected.
- Overflow case -2^31 / -1: result wraps to `lo_out`=0x80000000, `hi_out`=0. No flag is raised; overflow is not this block's concern.
- Sign rules: the quotient truncates toward zero and the remainder takes the dividend's sign, matching MIPS `div`.
- `div_done` and `divzero` are never high in the same cycle.

Test Plan:
- 7 / 2, start at edge 0 → `busy` high for 32 cycles; at edge 33 `div_done`=1, `lo_out`=3, `hi_out`=1; `div_done` low again at edge 34.
- -7 / 2 → `lo_out`=0xFFFFFFFD, `hi_out`=0xFFFFFFFF. Then 7 / -2 → `lo_out`=0xFFFFFFFD, `hi_out`=1. Then -7 / -2 → `lo_out`=3, `hi_out`=0xFFFFFFFF.
- 5 / 0 after a prior 7 / 2 → `divzero`=1 for one cycle, `div_done` never rises, `busy` stays 0, `hi_out`/`lo_out` remain 1/3.
- 0x80000000 / 0xFFFFFFFF → `lo_out`=0x80000000, `hi_out`=0. Then 0x80000000 / 1 → `lo_out`=0x80000000, `hi_out`=0.
- 100 / 7, with a second `div_start` carrying 9 / 3 at cycle 10 → only one `div_done`, at edge 33, with `lo_out`=14, `hi_out`=2.
- 100 / 7 with `reset` pulsed asynchronously mid-cycle at cycle 15 → all outputs 0 immediately, no `div_done` within 40 cycles. A new 9 / 3 then completes in 33 cycles with `lo_out`=3, `hi_out`=0.
